// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin N-channel arbiter serialising request/ack
// masters onto one single-port synchronous RAM with a configurable read latency.
// Optional macro RAM_ARB_LOCK_EN adds lock_i, which lets a channel keep
// the RAM for back-to-back transactions while holding its request.
module ram_arbiter #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int RAM_LATENCY = 1,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     sys_clk_i,
   input  logic                     rst_i,
   input  logic [NUM_CH-1:0]        req_i,
   input  logic [NUM_CH-1:0]        we_i,
   input  logic [NUM_CH*ADDR_W-1:0] addr_i,
   input  logic [NUM_CH*DATA_W-1:0] wdata_i,
`ifdef RAM_ARB_LOCK_EN
   input  logic [NUM_CH-1:0]        lock_i,
`endif
   output logic [NUM_CH-1:0]        ack_o,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     busy_o,
   output logic [CH_W-1:0]          grant_id_o,
   output logic                     ram_en_o,
   output logic                     ram_we_o,
   output logic [ADDR_W-1:0]        ram_addr_o,
   output logic [DATA_W-1:0]        ram_wdata_o,
   input  logic [DATA_W-1:0]        ram_rdata_i
);

   localparam int CNT_W     = (RAM_LATENCY > 2) ? $clog2(RAM_LATENCY) : 1;
   localparam int WAIT_LAST = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   state_t              r_state;
   logic [CH_W-1:0]     r_ptr;
   logic [CH_W-1:0]     r_gid;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_ram_en;
   logic                r_ram_we;
   logic                r_busy;
   logic [NUM_CH-1:0]   r_ack;
   logic [DATA_W-1:0]   r_rdata;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_locked;

   logic                w_any;
   logic                w_hold;
   logic [CH_W-1:0]     w_sel;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic [NUM_CH-1:0]   w_ack_vec;
   logic                w_lock_now;

   // Round-robin pick: first requester above the pointer, then wrap to the ones at or below it
   always_comb begin
      w_any  = 1'b0;
      w_hold = 1'b0;
      w_sel  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!w_any && req_i[c] && (c > int'(r_ptr))) begin
            w_any = 1'b1;
            w_sel = CH_W'(c);
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (!w_any && req_i[c] && (c <= int'(r_ptr))) begin
            w_any = 1'b1;
            w_sel = CH_W'(c);
         end
      end
      // A locked channel that still requests overrides the rotation
      for (int c = 0; c < NUM_CH; c++) begin
         if (r_locked && req_i[c] && (CH_W'(c) == r_gid)) begin
            w_hold = 1'b1;
            w_any  = 1'b1;
            w_sel  = CH_W'(c);
         end
      end
   end

   // Steer the selected channel's command and decode the ack / lock of the served channel
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_ack_vec   = '0;
      w_lock_now  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (CH_W'(c) == w_sel) begin
            w_sel_we    = we_i[c];
            w_sel_addr  = addr_i[c*ADDR_W +: ADDR_W];
            w_sel_wdata = wdata_i[c*DATA_W +: DATA_W];
         end
         if (CH_W'(c) == r_gid) begin
            w_ack_vec[c] = 1'b1;
`ifdef RAM_ARB_LOCK_EN
            w_lock_now   = lock_i[c];
`endif
         end
      end
   end

   // Arbitration FSM with registered RAM strobes, ack pulse, status and read-data hold
   always_ff @(posedge sys_clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= S_IDLE;
         r_ptr    <= CH_W'(NUM_CH - 1);
         r_gid    <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ram_en <= 1'b0;
         r_ram_we <= 1'b0;
         r_busy   <= 1'b0;
         r_ack    <= '0;
         r_rdata  <= '0;
         r_cnt    <= '0;
         r_locked <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_locked <= w_hold;
               if (w_any) begin
                  r_gid    <= w_sel;
                  r_we     <= w_sel_we;
                  r_addr   <= w_sel_addr;
                  r_wdata  <= w_sel_wdata;
                  r_ram_en <= 1'b1;
                  r_ram_we <= w_sel_we;
                  r_busy   <= 1'b1;
                  r_state  <= S_ISSUE;
                  if (!w_hold) begin
                     r_ptr <= w_sel;
                  end
               end
            end
            S_ISSUE: begin
               r_ram_en <= 1'b0;
               r_ram_we <= 1'b0;
               r_cnt    <= '0;
               if (RAM_LATENCY > 1) begin
                  r_state <= S_WAIT;
               end else begin
                  r_ack   <= w_ack_vec;
                  r_state <= S_ACK;
               end
            end
            S_WAIT: begin
               if (r_cnt == CNT_W'(WAIT_LAST)) begin
                  r_ack   <= w_ack_vec;
                  r_state <= S_ACK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_ACK: begin
               r_ack    <= '0;
               r_busy   <= 1'b0;
               r_locked <= w_lock_now;
               r_state  <= S_IDLE;
               if (!r_we) begin
                  r_rdata <= ram_rdata_i;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read data is presented straight from the RAM in the ack cycle, then held in r_rdata
   assign rdata_o     = ((r_state == S_ACK) && !r_we) ? ram_rdata_i : r_rdata;
   assign ack_o       = r_ack;
   assign busy_o      = r_busy;
   assign grant_id_o  = r_gid;
   assign ram_en_o    = r_ram_en;
   assign ram_we_o    = r_ram_we;
   assign ram_addr_o  = r_addr;
   assign ram_wdata_o = r_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance A (2 channels, latency 1) and
// instance B (4 channels, latency 3), each with a behavioural RAM and a
// scoreboard queue of expected (channel, read data) per acknowledge.
module tb_ram_arbiter;

   typedef struct {
      int          ch;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] a_init(input int i);
      return (i == 3) ? 32'hDEADBEEF : (32'hA500_0000 + 32'(i));
   endfunction

   function automatic logic [31:0] b_init(input int i);
      return 32'hB0B0_0000 + 32'(i * 17);
   endfunction

   // ---------------- instance A ----------------
   logic        rst_a_n = 1'b0;
   logic [1:0]  a_req = '0, a_we = '0;
   logic [9:0]  a_addr = '0;
   logic [63:0] a_wdata = '0;
   logic [1:0]  a_ack;
   logic [31:0] a_rdata, a_ram_wdata, a_ram_rdata;
   logic        a_busy, a_ram_en, a_ram_we;
   logic [0:0]  a_gid;
   logic [4:0]  a_ram_addr;
   logic [1:0]  lock_a = '0;
   logic [31:0] mem_a [32];
   logic [31:0] ref_a [32];
   logic [31:0] a_last_rd = '0;
   exp_t        qa[$];
   exp_t        ea;

   ram_arbiter #(.NUM_CH(2), .ADDR_W(5), .DATA_W(32), .RAM_LATENCY(1)) u_a (
      .sys_clk_i(clk), .rst_i(rst_a_n), .req_i(a_req), .we_i(a_we),
      .addr_i(a_addr), .wdata_i(a_wdata),
`ifdef RAM_ARB_LOCK_EN
      .lock_i(lock_a),
`endif
      .ack_o(a_ack), .rdata_o(a_rdata), .busy_o(a_busy), .grant_id_o(a_gid),
      .ram_en_o(a_ram_en), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr),
      .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata));

   always @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         for (int i = 0; i < 32; i++) mem_a[i] <= a_init(i);
         a_ram_rdata <= '0;
      end else if (a_ram_en) begin
         if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
         else          a_ram_rdata <= mem_a[a_ram_addr];
      end
   end

   always @(negedge clk) begin
      if (a_ack != 2'b00) begin
         if (qa.size() == 0) begin
            check_val("a_unexpected_ack", 64'(a_ack), 64'd0);
         end else begin
            ea = qa.pop_front();
            check_val("a_ack_onehot", 64'(a_ack), 64'(2'(1) << ea.ch));
            check_val("a_grant_id", 64'(a_gid), 64'(ea.ch));
            check_val("a_rdata", 64'(a_rdata), 64'(ea.data));
         end
      end
   end

   function automatic exp_t a_expect(input int ch, input bit we, input logic [4:0] addr,
                                     input logic [31:0] wd);
      exp_t e;
      e.ch = ch;
      if (we) begin
         e.data = a_last_rd;
         ref_a[addr] = wd;
      end else begin
         e.data = ref_a[addr];
         a_last_rd = ref_a[addr];
      end
      return e;
   endfunction

   // Single uncontended transaction with cycle-exact checks
   task automatic a_txn(input int ch, input bit we, input logic [4:0] addr, input logic [31:0] wd);
      int t;
      logic [1:0] m;
      m = 2'(1) << ch;
      t = 0;
      @(negedge clk);
      while (a_busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      check_val("a_idle_before", 64'(a_busy), 64'd0);
      a_req = a_req | m;
      a_we  = we ? (a_we | m) : (a_we & ~m);
      a_addr[ch*5 +: 5]   = addr;
      a_wdata[ch*32 +: 32] = wd;
      qa.push_back(a_expect(ch, we, addr, wd));
      @(negedge clk);
      check_val("a_issue_en", 64'(a_ram_en), 64'd1);
      check_val("a_issue_we", 64'(a_ram_we), 64'(we));
      check_val("a_issue_addr", 64'(a_ram_addr), 64'(addr));
      check_val("a_issue_busy", 64'(a_busy), 64'd1);
      if (we) check_val("a_issue_wdata", 64'(a_ram_wdata), 64'(wd));
      @(negedge clk);
      check_val("a_ack_cycle", 64'(a_ack), 64'(m));
      check_val("a_ack_en", 64'(a_ram_en), 64'd0);
      check_val("a_ack_we", 64'(a_ram_we), 64'd0);
      a_req = a_req & ~m;
      @(negedge clk);
      check_val("a_busy_after", 64'(a_busy), 64'd0);
      check_val("a_ack_after", 64'(a_ack), 64'd0);
   endtask

   // ---------------- instance B ----------------
   logic         rst_b_n = 1'b0;
   logic [3:0]   b_req = '0, b_we = '0;
   logic [19:0]  b_addr = '0;
   logic [127:0] b_wdata = '0;
   logic [3:0]   b_ack;
   logic [31:0]  b_rdata, b_ram_wdata, b_ram_rdata;
   logic         b_busy, b_ram_en, b_ram_we;
   logic [1:0]   b_gid;
   logic [4:0]   b_ram_addr;
   logic [3:0]   lock_b = '0;
   logic [31:0]  mem_b [32];
   logic [31:0]  b_p0, b_p1;
   exp_t         qb[$];
   exp_t         eb;

   ram_arbiter #(.NUM_CH(4), .ADDR_W(5), .DATA_W(32), .RAM_LATENCY(3)) u_b (
      .sys_clk_i(clk), .rst_i(rst_b_n), .req_i(b_req), .we_i(b_we),
      .addr_i(b_addr), .wdata_i(b_wdata),
`ifdef RAM_ARB_LOCK_EN
      .lock_i(lock_b),
`endif
      .ack_o(b_ack), .rdata_o(b_rdata), .busy_o(b_busy), .grant_id_o(b_gid),
      .ram_en_o(b_ram_en), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
      .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata));

   always @(posedge clk or negedge rst_b_n) begin
      if (!rst_b_n) begin
         for (int i = 0; i < 32; i++) mem_b[i] <= b_init(i);
         b_p0 <= '0;
         b_p1 <= '0;
         b_ram_rdata <= '0;
      end else begin
         if (b_ram_en) begin
            if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
            b_p0 <= mem_b[b_ram_addr];
         end
         b_p1 <= b_p0;
         b_ram_rdata <= b_p1;
      end
   end

   always @(negedge clk) begin
      if (b_ack != 4'b0000) begin
         if (qb.size() == 0) begin
            check_val("b_unexpected_ack", 64'(b_ack), 64'd0);
         end else begin
            eb = qb.pop_front();
            check_val("b_ack_onehot", 64'(b_ack), 64'(4'(1) << eb.ch));
            check_val("b_grant_id", 64'(b_gid), 64'(eb.ch));
            check_val("b_rdata", 64'(b_rdata), 64'(eb.data));
         end
      end
   end

   // Wait for a number of B acks; optionally drop each served request and check ack spacing
   task automatic b_wait(input int target, input bit drop_each, input bit spacing, input int t0);
      int seen, last;
      seen = 0;
      last = -1;
      for (int t = 0; t < 300 && seen < target; t++) begin
         @(negedge clk);
         if (b_ack != 4'b0000) begin
            seen++;
            if (last < 0 && t0 >= 0) check_val("b_first_latency", 64'(cyc - t0), 64'd4);
            if (spacing && last >= 0) check_val("b_ack_spacing", 64'(cyc - last), 64'd5);
            last = cyc;
            if (drop_each) b_req = b_req & ~b_ack;
            if (seen == target) b_req = '0;
         end
      end
      check_val("b_ack_count", 64'(seen), 64'(target));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, t0;
      exp_t e;
      for (int i = 0; i < 32; i++) ref_a[i] = a_init(i);
      repeat (3) @(negedge clk);
      check_val("a_rst_ack", 64'(a_ack), 64'd0);
      check_val("a_rst_busy", 64'(a_busy), 64'd0);
      check_val("a_rst_en", 64'(a_ram_en), 64'd0);
      check_val("a_rst_rdata", 64'(a_rdata), 64'd0);
      check_val("b_rst_gid", 64'(b_gid), 64'd0);
      check_val("b_rst_busy", 64'(b_busy), 64'd0);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // A: two channels contending, strict alternation starting at channel 0
      @(negedge clk);
      a_we   = 2'b00;
      a_addr = {5'd31, 5'd3};
      for (int k = 0; k < 3; k++) begin
         qa.push_back(a_expect(0, 1'b0, 5'd3, 32'd0));
         qa.push_back(a_expect(1, 1'b0, 5'd31, 32'd0));
      end
      a_req = 2'b11;
      n = 0;
      for (int t = 0; t < 100 && n < 6; t++) begin
         @(negedge clk);
         if (a_ack != 2'b00) begin
            n++;
            if (n == 6) a_req = 2'b00;
         end
      end
      check_val("a_contend_acks", 64'(n), 64'd6);

      // A: single read, then write and read-back on channel 0
      a_txn(1, 1'b0, 5'd3, 32'd0);
      a_txn(0, 1'b1, 5'd31, 32'h12345678);
      a_txn(0, 1'b0, 5'd31, 32'd0);

`ifdef RAM_ARB_LOCK_EN
      // A: channel 1 holds the RAM via lock while channel 0 waits
      @(negedge clk);
      @(negedge clk);
      a_we   = 2'b00;
      a_addr = {5'd5, 5'd3};
      for (int k = 0; k < 3; k++) qa.push_back(a_expect(1, 1'b0, 5'd5, 32'd0));
      qa.push_back(a_expect(0, 1'b0, 5'd3, 32'd0));
      lock_a = 2'b10;
      a_req  = 2'b10;
      n = 0;
      for (int t = 0; t < 200 && n < 4; t++) begin
         @(negedge clk);
         if (a_ack != 2'b00) begin
            n++;
            if (n == 1) a_req = a_req | 2'b01;
            if (n == 3) begin
               lock_a = 2'b00;
               a_req  = a_req & 2'b01;
            end
            if (n == 4) a_req = 2'b00;
         end
      end
      check_val("a_lock_acks", 64'(n), 64'd4);
`endif

      // B: four channels all requesting, latency 3
      @(negedge clk);
      for (int k = 0; k < 4; k++) b_addr[k*5 +: 5] = 5'(4 + k);
      for (int k = 0; k < 5; k++) begin
         e.ch = k % 4;
         e.data = b_init(4 + (k % 4));
         qb.push_back(e);
      end
      b_req = 4'hF;
      t0 = cyc;
      b_wait(5, 1'b0, 1'b1, t0);

      // B: reset in the WAIT phase aborts the access
      @(negedge clk);
      @(negedge clk);
      b_addr[10 +: 5] = 5'd6;
      b_req = 4'b0100;
      @(negedge clk);
      check_val("b_mid_issue_en", 64'(b_ram_en), 64'd1);
      @(negedge clk);
      check_val("b_mid_wait_busy", 64'(b_busy), 64'd1);
      check_val("b_mid_wait_en", 64'(b_ram_en), 64'd0);
      #1;
      rst_b_n = 1'b0;
      qb.delete();
      #1;
      check_val("b_rst_ack", 64'(b_ack), 64'd0);
      check_val("b_rst_busy_mid", 64'(b_busy), 64'd0);
      check_val("b_rst_en_mid", 64'(b_ram_en), 64'd0);
      check_val("b_rst_we_mid", 64'(b_ram_we), 64'd0);
      check_val("b_rst_addr_mid", 64'(b_ram_addr), 64'd0);
      check_val("b_rst_gid_mid", 64'(b_gid), 64'd0);
      check_val("b_rst_rdata_mid", 64'(b_rdata), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check_val("b_rst_no_ack", 64'(b_ack), 64'd0);
      end
      b_req = '0;
      rst_b_n = 1'b1;
      @(negedge clk);
      e.ch = 0; e.data = b_init(4); qb.push_back(e);
      e.ch = 3; e.data = b_init(7); qb.push_back(e);
      b_req = 4'b1001;
      b_wait(2, 1'b1, 1'b0, -1);

      repeat (4) @(negedge clk);
      check_val("a_queue_empty", 64'(qa.size()), 64'd0);
      check_val("b_queue_empty", 64'(qb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
